// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state type and constants for the I2C register target
package i2c_pkg;

    localparam int ADDR_W    = 7;
    localparam int BYTE_BITS = 8;
    localparam int CNT_W     = $clog2(BYTE_BITS);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        IGNORE
    } i2c_state_t;

endpackage

// File: rtl/i2c_sync_filter.sv
// rtl/i2c_sync_filter.sv - 2-flop synchronizer plus optional 3-sample majority filter
// (enabled by I2C_SLAVE_GLITCH_FILTER_EN)
module i2c_sync_filter (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [1:0] sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], din};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [2:0] hist;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= 3'b111;
        end else begin
            hist <= {hist[1:0], sync[1]};
        end
    end

    // A level must be seen in two of the last three samples, so single-cycle pulses vanish.
    assign dout = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
`else
    assign dout = sync[1];
`endif

endmodule

// File: rtl/i2c_slave_regs.sv
// rtl/i2c_slave_regs.sv - I2C target exposing NREGS 8-bit registers with an auto-incrementing pointer
module i2c_slave_regs
    import i2c_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SLAVE_ADDR = 7'h50,
    parameter int                NREGS      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     scl,
    inout  wire                      sda,
    output logic [8*NREGS-1:0]       regs_flat,
    output logic                     wr_pulse,
    output logic [$clog2(NREGS)-1:0] wr_idx,
    output logic                     busy
);

    localparam int PW = $clog2(NREGS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_BITS - 1);

    logic                 scl_s, sda_s, scl_d, sda_d;
    logic                 scl_rise, scl_fall, start, stop, last_bit;
    i2c_state_t           state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [BYTE_BITS-2:0] shift;
    logic [BYTE_BITS-1:0] rx_next, tx, cur;
    logic [PW-1:0]        ptr;
    logic [BYTE_BITS-1:0] regs [NREGS];
    logic                 sda_oe, rw, ptr_pending;

    i2c_sync_filter u_scl_sync (.clk(clk), .rst(rst), .din(scl), .dout(scl_s));
    i2c_sync_filter u_sda_sync (.clk(clk), .rst(rst), .din(sda), .dout(sda_s));

    assign sda = sda_oe ? 1'b0 : 1'bz;

    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start    = scl_s & sda_d & ~sda_s;
    assign stop     = scl_s & ~sda_d & sda_s;
    assign last_bit = (cnt == LAST_BIT);
    assign rx_next  = {shift, sda_s};
    assign cur      = regs[ptr];

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = regs[g];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // In the ACK states sda_oe doubles as the phase flag: first falling edge drives, second ends the ACK.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ADDR;
        end else if (stop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                ADDR:     if (scl_rise && last_bit)
                              state_nxt = (rx_next[7:1] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
                ADDR_ACK: if (scl_fall && sda_oe) state_nxt = rw ? RD_BYTE : WR_BYTE;
                WR_BYTE:  if (scl_rise && last_bit) state_nxt = WR_ACK;
                WR_ACK:   if (scl_fall && sda_oe) state_nxt = WR_BYTE;
                RD_BYTE:  if (scl_rise && last_bit) state_nxt = RD_ACK;
                RD_ACK: begin
                    if (scl_rise && sda_s) state_nxt = IGNORE;
                    else if (scl_fall && cnt != '0) state_nxt = RD_BYTE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_d       <= 1'b1;
            sda_d       <= 1'b1;
            cnt         <= '0;
            shift       <= '0;
            tx          <= '0;
            ptr         <= '0;
            sda_oe      <= 1'b0;
            rw          <= 1'b0;
            ptr_pending <= 1'b0;
            busy        <= 1'b0;
            wr_pulse    <= 1'b0;
            wr_idx      <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            scl_d    <= scl_s;
            sda_d    <= sda_s;
            wr_pulse <= 1'b0;
            if (start) begin
                cnt    <= '0;
                sda_oe <= 1'b0;
            end else if (stop) begin
                cnt    <= '0;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        shift <= rx_next[BYTE_BITS-2:0];
                        cnt   <= cnt + CNT_W'(1);
                        if (last_bit && rx_next[7:1] == SLAVE_ADDR) begin
                            busy        <= 1'b1;
                            rw          <= rx_next[0];
                            ptr_pending <= 1'b1;
                        end
                    end
                    ADDR_ACK, WR_ACK: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else if (state == ADDR_ACK && rw) begin
                            sda_oe <= ~cur[7];
                            tx     <= {cur[6:0], 1'b0};
                            cnt    <= '0;
                        end else begin
                            sda_oe <= 1'b0;
                            cnt    <= '0;
                        end
                    end
                    WR_BYTE: if (scl_rise) begin
                        shift <= rx_next[BYTE_BITS-2:0];
                        cnt   <= cnt + CNT_W'(1);
                        if (last_bit) begin
                            if (ptr_pending) begin
                                ptr         <= rx_next[PW-1:0];
                                ptr_pending <= 1'b0;
                            end else begin
                                regs[ptr] <= rx_next;
                                wr_pulse  <= 1'b1;
                                wr_idx    <= ptr;
                                ptr       <= ptr + PW'(1);
                            end
                        end
                    end
                    RD_BYTE: begin
                        if (scl_rise) begin
                            cnt <= cnt + CNT_W'(1);
                            if (last_bit) ptr <= ptr + PW'(1);
                        end else if (scl_fall) begin
                            sda_oe <= ~tx[7];
                            tx     <= {tx[6:0], 1'b0};
                        end
                    end
                    // cnt records a master ACK seen on the 9th rising edge.
                    RD_ACK: begin
                        if (scl_rise) begin
                            if (!sda_s) cnt <= CNT_W'(1);
                        end else if (scl_fall) begin
                            if (cnt == '0) begin
                                sda_oe <= 1'b0;
                            end else begin
                                sda_oe <= ~cur[7];
                                tx     <= {cur[6:0], 1'b0};
                                cnt    <= '0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_slave_regs.md
I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

Interface
REQ-001 Parameter SLAVE_ADDR: default 7'h50; the 7-bit bus address this target answers.
REQ-002 Parameter NREGS: default 4; number of 8-bit registers. SHALL be a power of two, 2..16.
REQ-003 clk  input  1  system clock; at least 16x the SCL frequency.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 scl  input  1  I2C clock; never driven by this block.
REQ-006 sda  inout  1  I2C data, open-drain: driven 0, otherwise high-Z.
REQ-007 regs_flat  output  8*NREGS  register contents; reg[i] is bits [8i+7:8i].
REQ-008 wr_pulse  output  1  one-clk pulse each time a register is written.
REQ-009 wr_idx  output  $clog2(NREGS)  index of the register written; valid with wr_pulse.
REQ-010 busy  output  1  high from an address-matched START until STOP.

Function
REQ-011 scl and sda SHALL pass through a 2-flop synchronizer before any use; all logic runs on clk.
REQ-012 START detection: synced sda falls while synced scl is high. STOP detection: synced sda rises while scl is high.
REQ-013 Bits SHALL be sampled on a synced scl rising edge; sda drive changes SHALL occur only on a synced scl falling edge.
REQ-014 States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
REQ-015 A START in any state SHALL clear the bit counter and enter ADDR; this includes a repeated START.
REQ-016 A STOP in any state SHALL enter IDLE, release sda, clear busy and discard any partial byte.
REQ-017 ADDR: shift in 8 bits MSB first. If bits[7:1]==SLAVE_ADDR, go to ADDR_ACK and set busy; otherwise go to IGNORE with sda released, so the master sees a NACK.
REQ-018 ADDR_ACK: drive sda=0 for the 9th clock. Then enter WR_BYTE if R/W=0, or RD_BYTE if R/W=1.
REQ-019 Write transfer, first byte: loads the register pointer ptr = byte mod NREGS.
REQ-020 Write transfer, each later byte: writes reg[ptr], pulses wr_pulse with wr_idx=ptr, then increments ptr modulo NREGS (wraps).
REQ-021 WR_ACK: ACK every byte by driving sda=0 for the 9th clock, then return to WR_BYTE.
REQ-022 The register write and wr_pulse SHALL occur within 2 clk of the 8th-bit scl rising edge.
REQ-023 RD_BYTE: drive reg[ptr] MSB first, with the first bit driven on the scl falling edge that ends the ACK. Increment ptr (wrapping) after the 8th bit.
REQ-024 RD_ACK: release sda and sample it. Master ACK (0) goes to RD_BYTE; master NACK (1) goes to IGNORE.
REQ-025 IGNORE: sda released; leave only on START or STOP.
REQ-026 ptr SHALL persist across transactions until reset.

Reset
REQ-027 On rst low: state=IDLE, sda released, regs_flat=0, ptr=0, wr_pulse=0, wr_idx=0, busy=0, synchronizers set to 1.
REQ-028 Reset mid-transfer SHALL release sda immediately (asynchronously). After reset, the block waits for a new START.

Configuration
REQ-029 Macro I2C_SLAVE_GLITCH_FILTER_EN defined: scl and sda pass through a 3-sample majority filter after the synchronizer. This adds 2 clk of latency, and pulses of 1 clk or less are ignored.
REQ-030 Macro I2C_SLAVE_GLITCH_FILTER_EN undefined: no filter; synchronizer outputs are used directly.

Structure
REQ-031 Package i2c_pkg SHALL hold the state enum type, the constant for 7-bit address width, and the constant for bits per byte (8).
REQ-032 Sub-module i2c_sync_filter SHALL contain the synchronizer and the optional filter; it is instantiated once for scl and once for sda.

Verification
REQ-033 Write 0x50+W, 0x01, 0xA5, STOP -> three ACKs; regs_flat[15:8]=0xA5; one wr_pulse with wr_idx=1; busy low after STOP.
REQ-034 Address 0x51+W -> sda high at the 9th clock; no wr_pulse; regs unchanged; busy stays 0.
REQ-035 Preset reg2=0x11 and reg3=0x22. Write 0x50+W, 0x02; repeated START; 0x50+R; master reads two bytes (ACK then NACK) -> bus carries 0x11 then 0x22; ptr wraps to 0.
REQ-036 Write 0x50+W, 0x03, then data 0xAA, 0xBB -> reg3=0xAA and reg0=0xBB (wrap-around).
REQ-037 STOP after 4 data bits, then a new write of 0x50+W, 0x00, 0x5C -> partial byte discarded; reg0=0x5C.
REQ-038 With I2C_SLAVE_GLITCH_FILTER_EN defined, inject a 1-clk low pulse on scl mid-byte -> no extra bit shifted; the received byte is correct.
